// File: rtl/acc_byte_streamer_pkg.sv
// Shared accumulator command/status codes, streamer FSM states and
// word/byte count derivation from the compression width.
package acc_byte_streamer_pkg;

  localparam logic [3:0] ACC_CMD_IDLE    = 4'd0;
  localparam logic [3:0] ACC_CMD_OUT     = 4'd3;
  localparam logic [3:0] ACC_ST_IDLE     = 4'd0;
  localparam logic [3:0] ACC_ST_OUT      = 4'd3;
  localparam logic [3:0] ACC_ST_OUT_DONE = 4'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  function automatic int words_of(input int dd);
    return dd * 8;
  endfunction

  function automatic int nbytes_of(input int dd);
    return dd * 32;
  endfunction

endpackage

// File: rtl/acc_byte_streamer_serializer.sv
// Holds one {b,a} word pair and presents it as four valid/ready bytes,
// little-endian with a first; flags the final byte of the last word.
module acc_byte_serializer
  import acc_byte_streamer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        set,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        last_word,
  input  logic        clear,
  input  logic        byte_ready,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        byte_last,
  output logic        word_done
);

  logic [31:0] word_r;
  logic [1:0]  sel_r;
  logic [7:0]  byte_r;
  logic        valid_r;
  logic        last_word_r;
  logic        last_r;
  logic        handshake_s;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] s);
    logic [7:0] r;
    case (s)
      2'd0:    r = w[7:0];
      2'd1:    r = w[15:8];
      2'd2:    r = w[23:16];
      2'd3:    r = w[31:24];
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  assign handshake_s = valid_r & byte_ready;
  assign word_done   = handshake_s & (sel_r == 2'd3);
  assign byte_out    = byte_r;
  assign byte_valid  = valid_r;
  assign byte_last   = last_r;

  // byte/last only move on load or accepted handshake, so they are stable under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      word_r      <= 32'd0;
      sel_r       <= 2'd0;
      byte_r      <= 8'd0;
      valid_r     <= 1'b0;
      last_word_r <= 1'b0;
      last_r      <= 1'b0;
    end else if (set) begin
      if (load) begin
        word_r      <= word;
        sel_r       <= 2'd0;
        byte_r      <= word[7:0];
        valid_r     <= 1'b1;
        last_word_r <= last_word;
        last_r      <= 1'b0;
      end else if (clear) begin
        valid_r <= 1'b0;
        last_r  <= 1'b0;
      end else if (handshake_s) begin
        if (sel_r == 2'd3) begin
          valid_r <= 1'b0;
          last_r  <= 1'b0;
          sel_r   <= 2'd0;
        end else begin
          sel_r  <= sel_r + 2'd1;
          byte_r <= byte_of(word_r, sel_r + 2'd1);
          last_r <= last_word_r & (sel_r == 2'd2);
        end
      end
    end
  end

endmodule

// File: rtl/acc_byte_streamer.sv
// Drives the accumulator readout (cmd 3) after encode and streams the
// DD*8 word pairs out as 32*DD bytes, with a progress timeout.
module acc_byte_streamer
  import acc_byte_streamer_pkg::*;
#(
  parameter int DD      = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set,
  input  logic        start,
  output logic [3:0]  acc_cmd,
  output logic        acc_readout,
  input  logic [3:0]  acc_status,
  input  logic [6:0]  acc_addr,
  input  logic [15:0] acc_data_a,
  input  logic [15:0] acc_data_b,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        byte_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int         WORDS    = words_of(DD);
  localparam logic [6:0] LAST_IDX = 7'(WORDS - 1);
  localparam logic [4:0] TMO_LIM  = 5'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic [3:0]  acc_cmd_r, acc_cmd_s;
  logic        readout_r, readout_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        err_r, err_s;
  logic [6:0]  word_idx_r, word_idx_s;
  logic [4:0]  tmo_r, tmo_s;
  logic        load_s, clear_s, capture_s, counting_s, word_done_s;

  assign capture_s  = (acc_addr == word_idx_r) &&
                      ((acc_status == ACC_ST_OUT) || (acc_status == ACC_ST_OUT_DONE));
  assign counting_s = (state_r == ST_REQ) || (state_r == ST_LOAD);

  // next-state and registered-output computation
  always_comb begin
    state_s    = state_r;
    acc_cmd_s  = acc_cmd_r;
    readout_s  = 1'b0;
    busy_s     = busy_r;
    done_s     = 1'b0;
    err_s      = err_r;
    word_idx_s = word_idx_r;
    load_s     = 1'b0;
    clear_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s    = ST_REQ;
          acc_cmd_s  = ACC_CMD_OUT;
          busy_s     = 1'b1;
          err_s      = 1'b0;
          word_idx_s = 7'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (acc_status == ACC_ST_OUT) begin
          state_s = ST_LOAD;
        end else if (tmo_r == TMO_LIM) begin
          state_s = ST_ABORT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_LOAD: begin
        if (capture_s) begin
          load_s    = 1'b1;
          readout_s = (word_idx_r != LAST_IDX);
          state_s   = ST_SEND;
        end else if (tmo_r == TMO_LIM) begin
          state_s = ST_ABORT;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_SEND: begin
        if (word_done_s) begin
          if (word_idx_r == LAST_IDX) begin
            state_s   = ST_DONE;
            acc_cmd_s = ACC_CMD_IDLE;
          end else begin
            word_idx_s = word_idx_r + 7'd1;
            state_s    = ST_LOAD;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_DONE: begin
        acc_cmd_s = ACC_CMD_IDLE;
        clear_s   = 1'b1;
        if (acc_status == ACC_ST_IDLE) begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
          done_s  = ~err_r;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_ABORT: begin
        err_s     = 1'b1;
        acc_cmd_s = ACC_CMD_IDLE;
        clear_s   = 1'b1;
        state_s   = ST_DONE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // timeout restarts on every state entry and only runs while waiting on the accumulator
    tmo_s = (state_s != state_r) ? 5'd0 : (counting_s ? tmo_r + 5'd1 : tmo_r);
  end

  // state and control registers; set=0 freezes everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      acc_cmd_r  <= ACC_CMD_IDLE;
      readout_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      word_idx_r <= 7'd0;
      tmo_r      <= 5'd0;
    end else if (set) begin
      state_r    <= state_s;
      acc_cmd_r  <= acc_cmd_s;
      readout_r  <= readout_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
      word_idx_r <= word_idx_s;
      tmo_r      <= tmo_s;
    end
  end

  acc_byte_serializer u_ser (
    .clk        (clk),
    .reset      (reset),
    .set        (set),
    .load       (load_s),
    .word       ({acc_data_b, acc_data_a}),
    .last_word  (word_idx_r == LAST_IDX),
    .clear      (clear_s),
    .byte_ready (byte_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .word_done  (word_done_s)
  );

  assign acc_cmd     = acc_cmd_r;
  assign acc_readout = readout_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;

endmodule

// File: tb/tb_acc_byte_streamer.sv
// Bench for acc_byte_streamer: DD=4 and DD=10 instances, each fed by a
// registered-read accumulator model; scenario table plus timeout sequence.
module tb_acc_byte_streamer;

  typedef struct {
    int inst;
    int rdy_rand;
    int rst_at;
    int gap_at;
    int exp_bytes;
    int exp_rdo;
    int exp_err;
    int exp_done;
  } scn_t;

  logic        clk = 1'b0;
  logic        reset, set, ready;
  logic        strt [2];
  logic [3:0]  cmd  [2];
  logic        rdo  [2];
  logic [3:0]  st   [2];
  logic [6:0]  addr [2];
  logic [15:0] da   [2];
  logic [15:0] db   [2];
  logic [7:0]  bo   [2];
  logic        bv   [2];
  logic        bl   [2];
  logic        bsy  [2];
  logic        dn   [2];
  logic        er   [2];
  logic [6:0]  mcnt [2];
  bit          stall_model;
  int          rdy_rand;

  int          idx [2];
  int          rcnt [2];
  int          dcnt [2];
  logic        stall_prev [2];
  logic [7:0]  prev_b [2];
  logic        prev_l [2];
  logic [3:0]  pst1 [2];
  logic [3:0]  pst2 [2];
  int          vec, bad;
  scn_t        tbl [5];

  always #5 clk = ~clk;

  acc_byte_streamer #(.DD(4), .TIMEOUT(16)) u4 (
    .clk(clk), .reset(reset), .set(set), .start(strt[0]),
    .acc_cmd(cmd[0]), .acc_readout(rdo[0]), .acc_status(st[0]), .acc_addr(addr[0]),
    .acc_data_a(da[0]), .acc_data_b(db[0]), .byte_out(bo[0]), .byte_valid(bv[0]),
    .byte_ready(ready), .byte_last(bl[0]), .busy(bsy[0]), .done(dn[0]), .err(er[0])
  );

  acc_byte_streamer #(.DD(10), .TIMEOUT(16)) u10 (
    .clk(clk), .reset(reset), .set(set), .start(strt[1]),
    .acc_cmd(cmd[1]), .acc_readout(rdo[1]), .acc_status(st[1]), .acc_addr(addr[1]),
    .acc_data_a(da[1]), .acc_data_b(db[1]), .byte_out(bo[1]), .byte_valid(bv[1]),
    .byte_ready(ready), .byte_last(bl[1]), .busy(bsy[1]), .done(dn[1]), .err(er[1])
  );

  // accumulator model: registered read, tag = counter delayed one cycle, status 6 on last word
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        st[i] <= 4'd0; mcnt[i] <= 7'd0; addr[i] <= 7'd0; da[i] <= 16'd0; db[i] <= 16'd0;
      end else if (set) begin
        if (cmd[i] != 4'd3) begin
          st[i] <= 4'd0; mcnt[i] <= 7'd0;
        end else begin
          if (rdo[i]) mcnt[i] <= mcnt[i] + 7'd1;
          if (!(stall_model && i == 0))
            st[i] <= (mcnt[i] == ((i == 0) ? 7'd31 : 7'd79)) ? 4'd6 : 4'd3;
          addr[i] <= mcnt[i];
          da[i]   <= 16'h1000 + {9'd0, mcnt[i]};
          db[i]   <= 16'h2000 + {9'd0, mcnt[i]};
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int n);
    case (n % 4)
      0, 2:    return 8'(n / 4);
      1:       return 8'h10;
      default: return 8'h20;
    endcase
  endfunction

  function automatic logic [17:0] outs(input int i);
    return {cmd[i], rdo[i], bo[i], bv[i], bl[i], bsy[i], dn[i], er[i]};
  endfunction

  // sample on the falling edge, then drive just after the rising edge
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        stall_prev[i] = 1'b0;
      end else begin
        if (stall_prev[i] && bv[i])
          check("hold_stable", {23'd0, bl[i], bo[i]}, {23'd0, prev_l[i], prev_b[i]});
        if (set && bv[i] && ready) begin
          check("stream_byte", {23'd0, bl[i], bo[i]},
                {23'd0, idx[i] == ((i == 0) ? 127 : 319), exp_byte(idx[i])});
          idx[i]++;
        end
        if (set && rdo[i]) rcnt[i]++;
        if (set && dn[i]) begin
          dcnt[i]++;
          check("done_after_st0", {30'd0, pst1[i] == 4'd0, pst2[i] != 4'd0}, 32'd3);
        end
        stall_prev[i] = bv[i] & ~(set & ready);
        prev_b[i] = bo[i];
        prev_l[i] = bl[i];
        if (set) begin
          pst2[i] = pst1[i];
          pst1[i] = st[i];
        end
      end
    end
    @(posedge clk);
    #1;
    ready = (rdy_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run_scn(input scn_t sc);
    int i;
    int cyc;
    bit rst_done, gap_done;
    i = sc.inst; cyc = 0; rst_done = 0; gap_done = 0;
    rdy_rand = sc.rdy_rand;
    idx[i] = 0; rcnt[i] = 0; dcnt[i] = 0;
    strt[i] = 1'b1; tick(); strt[i] = 1'b0;
    check("busy_on_start", {31'd0, bsy[i]}, 32'd1);
    while (bsy[i] && cyc < 4000) begin
      if (sc.rst_at >= 0 && !rst_done && idx[i] == sc.rst_at) begin
        rst_done = 1;
        reset = 1'b1; tick(); reset = 1'b0;
        check("reset_mid_outs", {14'd0, outs(i)}, 32'd0);
        idx[i] = 0; rcnt[i] = 0;
        strt[i] = 1'b1; tick(); strt[i] = 1'b0;
      end else if (sc.gap_at >= 0 && !gap_done && idx[i] == sc.gap_at) begin
        gap_done = 1;
        set = 1'b0; repeat (5) tick(); set = 1'b1;
        check("gap_no_advance", idx[i], sc.gap_at);
      end else begin
        tick();
      end
      cyc++;
    end
    check("busy_drop_in_budget", {31'd0, bsy[i]}, 32'd0);
    tick();
    check("byte_count", idx[i], sc.exp_bytes);
    check("readout_count", rcnt[i], sc.exp_rdo);
    check("err_flag", {31'd0, er[i]}, sc.exp_err);
    check("done_count", dcnt[i], sc.exp_done);
    check("acc_cmd_idle", {28'd0, cmd[i]}, 32'd0);
  endtask

  initial begin
    vec = 0; bad = 0; rdy_rand = 0; stall_model = 0;
    reset = 1'b1; set = 1'b1; ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      strt[i] = 1'b0; idx[i] = 0; rcnt[i] = 0; dcnt[i] = 0;
      stall_prev[i] = 1'b0; prev_b[i] = 8'd0; prev_l[i] = 1'b0;
      pst1[i] = 4'd0; pst2[i] = 4'd0;
    end
    //            inst rnd rst gap bytes rdo err done
    tbl[0] = '{0, 0, -1, -1, 128, 31, 0, 1};
    tbl[1] = '{1, 0, -1, -1, 320, 79, 0, 1};
    tbl[2] = '{0, 1, -1, -1, 128, 31, 0, 1};
    tbl[3] = '{0, 0, 37, -1, 128, 31, 0, 1};
    tbl[4] = '{0, 0, -1, 50, 128, 31, 0, 1};

    repeat (3) tick();
    check("reset_outs_dd4", {14'd0, outs(0)}, 32'd0);
    check("reset_outs_dd10", {14'd0, outs(1)}, 32'd0);
    reset = 1'b0;
    tick();

    // accumulator never reaches status 3: abort after TIMEOUT+1 cycles, no done
    stall_model = 1; dcnt[0] = 0;
    strt[0] = 1'b1; tick(); strt[0] = 1'b0;
    check("tmo_busy", {31'd0, bsy[0]}, 32'd1);
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 16) check("tmo_err_not_yet", {31'd0, er[0]}, 32'd0);
      if (k == 17) check("tmo_err_cmd", {27'd0, er[0], cmd[0]}, 32'h10);
    end
    for (int k = 0; k < 20 && bsy[0]; k++) tick();
    tick();
    check("tmo_busy_drop", {31'd0, bsy[0]}, 32'd0);
    check("tmo_no_done", dcnt[0], 32'd0);
    check("tmo_err_sticky", {31'd0, er[0]}, 32'd1);
    stall_model = 0;
    tick();

    for (int s = 0; s < 5; s++) run_scn(tbl[s]);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
